// File: rtl/miner_pkg.sv
// Shared types and defaults for the nonce-search controller.
package miner_pkg;
    localparam int MC_NONCE_W = 32;
    localparam int MC_HASH_W  = 256;
    localparam int MC_TIMEOUT = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CHECK,
        ST_NEXT,
        ST_FOUND,
        ST_EXHAUSTED,
        ST_ABORT
    } mc_state_t;

    // Resting states accept a new job and keep busy low
    function automatic logic is_resting(mc_state_t s);
        return (s == ST_IDLE) || (s == ST_FOUND) || (s == ST_EXHAUSTED);
    endfunction
endpackage

// File: rtl/mining_controller_if.sv
// Handshake between the search controller and the hashing module.
interface mining_controller_if #(
    parameter int NONCE_W = miner_pkg::MC_NONCE_W,
    parameter int HASH_W  = miner_pkg::MC_HASH_W
);
    logic               begin_hash;
    logic               quit_hash;
    logic [NONCE_W-1:0] nonce;
    logic               hash_done;
    logic [HASH_W-1:0]  hash_in;

    modport master (
        output begin_hash, quit_hash, nonce,
        input  hash_done, hash_in
    );

    modport slave (
        input  begin_hash, quit_hash, nonce,
        output hash_done, hash_in
    );
endinterface

// File: rtl/mc_wait_timer.sv
// Clear/enable up-counter flagging the last permitted WAIT cycle.
module mc_wait_timer #(
    parameter int TIMEOUT = miner_pkg::MC_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign tc = (cnt_q == CW'(TIMEOUT - 1));
endmodule

// File: rtl/mining_controller.sv
// Nonce-search sequencer: issues one hash per nonce until hit, wrap,
// timeout or abort.
module mining_controller
    import miner_pkg::*;
#(
    parameter int NONCE_W = MC_NONCE_W,
    parameter int HASH_W  = MC_HASH_W,
    parameter int TIMEOUT = MC_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_mine,
    input  logic               abort,
    input  logic [NONCE_W-1:0] nonce_start,
    input  logic [HASH_W-1:0]  target,
    mining_controller_if.master hif,
    output logic               busy,
    output logic               found,
    output logic               exhausted,
    output logic               timeout_err,
    output logic [NONCE_W-1:0] golden_nonce
);
    mc_state_t state_q, state_d;

    logic [NONCE_W-1:0] nonce_q, nonce_d;
    logic [NONCE_W-1:0] golden_q, golden_d;
    logic [HASH_W-1:0]  target_q, target_d;
    logic [HASH_W-1:0]  hash_q, hash_d;
    logic begin_q, begin_d;
    logic quit_q, quit_d;
    logic busy_q, busy_d;
    logic found_q, found_d;
    logic exh_q, exh_d;
    logic terr_q, terr_d;
    logic tmr_tc;

    mc_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (state_q == ST_ISSUE),
        .en  (state_q == ST_WAIT),
        .tc  (tmr_tc)
    );

    always_comb begin
        state_d  = state_q;
        nonce_d  = nonce_q;
        golden_d = golden_q;
        target_d = target_q;
        hash_d   = hash_q;
        found_d  = found_q;
        exh_d    = exh_q;
        terr_d   = terr_q;

        unique case (state_q)
            ST_IDLE, ST_FOUND, ST_EXHAUSTED: begin
                if (start_mine) begin
                    nonce_d  = nonce_start;
                    target_d = target;
                    found_d  = 1'b0;
                    exh_d    = 1'b0;
                    terr_d   = 1'b0;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (hif.hash_done) begin
                    hash_d  = hif.hash_in;
                    state_d = ST_CHECK;
                end else if (tmr_tc) begin
                    terr_d  = 1'b1;
                    state_d = ST_ABORT;
                end
            end
            ST_CHECK: begin
                if (hash_q < target_q) begin
                    golden_d = nonce_q;
                    found_d  = 1'b1;
                    state_d  = ST_FOUND;
                end else if (&nonce_q) begin
                    exh_d   = 1'b1;
                    state_d = ST_EXHAUSTED;
                end else begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                nonce_d = nonce_q + NONCE_W'(1);
                state_d = ST_ISSUE;
            end
            ST_ABORT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Abort wins over everything, including a same-cycle hit
        if (abort && !is_resting(state_q) && state_q != ST_ABORT) begin
            state_d = ST_ABORT;
            hash_d  = hash_q;
            found_d = found_q;
            exh_d   = exh_q;
            terr_d  = terr_q;
            golden_d = golden_q;
            nonce_d = nonce_q;
        end

        begin_d = (state_d == ST_ISSUE);
        quit_d  = (state_d == ST_ABORT);
        busy_d  = !is_resting(state_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            nonce_q  <= '0;
            golden_q <= '0;
            target_q <= '0;
            hash_q   <= '0;
            begin_q  <= 1'b0;
            quit_q   <= 1'b0;
            busy_q   <= 1'b0;
            found_q  <= 1'b0;
            exh_q    <= 1'b0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            nonce_q  <= nonce_d;
            golden_q <= golden_d;
            target_q <= target_d;
            hash_q   <= hash_d;
            begin_q  <= begin_d;
            quit_q   <= quit_d;
            busy_q   <= busy_d;
            found_q  <= found_d;
            exh_q    <= exh_d;
            terr_q   <= terr_d;
        end
    end

    assign hif.begin_hash = begin_q;
    assign hif.quit_hash  = quit_q;
    assign hif.nonce      = nonce_q;
    assign busy           = busy_q;
    assign found          = found_q;
    assign exhausted      = exh_q;
    assign timeout_err    = terr_q;
    assign golden_nonce   = golden_q;
endmodule

// File: tb/tb_mining_controller.sv
// Directed bench: job table against a behavioural hasher plus
// hand-timed abort, timeout and reset sequences.
module tb_mining_controller;
    localparam int NW  = 32;
    localparam int HW  = 256;
    localparam int TO  = 1024;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_mine;
    logic          abort;
    logic [NW-1:0] nonce_start;
    logic [HW-1:0] target;
    logic          busy, found, exhausted, timeout_err;
    logic [NW-1:0] golden_nonce;

    mining_controller_if #(.NONCE_W(NW), .HASH_W(HW)) hif ();

    mining_controller #(.NONCE_W(NW), .HASH_W(HW), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_mine   (start_mine),
        .abort        (abort),
        .nonce_start  (nonce_start),
        .target       (target),
        .hif          (hif.master),
        .busy         (busy),
        .found        (found),
        .exhausted    (exhausted),
        .timeout_err  (timeout_err),
        .golden_nonce (golden_nonce)
    );

    always #5 clk = ~clk;

    // Behavioural hasher: answers LAT negedges after seeing begin_hash
    logic          respond;
    logic [NW-1:0] m_hit_nonce;
    logic [HW-1:0] m_hit_hash, m_miss_hash;
    int            begins = 0;
    int            cnt = 0;
    bit            pend = 0;

    initial begin
        hif.hash_done = 1'b0;
        hif.hash_in   = '0;
    end

    always @(negedge clk) begin
        hif.hash_done = 1'b0;
        if (rst || hif.quit_hash) begin
            pend = 0;
        end else if (hif.begin_hash) begin
            pend = 1;
            cnt = LAT;
            begins++;
        end else if (pend) begin
            if (cnt == 1) begin
                pend = 0;
                if (respond) begin
                    hif.hash_done = 1'b1;
                    hif.hash_in = (hif.nonce == m_hit_nonce) ?
                                  m_hit_hash : m_miss_hash;
                end
            end else begin
                cnt--;
            end
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [HW-1:0] act,
                       input logic [HW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [NW-1:0] n_start;
        logic [HW-1:0] tgt;
        logic [NW-1:0] hit_n;
        logic [HW-1:0] hit_h;
        logic [HW-1:0] miss_h;
        logic          e_found;
        logic          e_exh;
        logic [NW-1:0] e_golden;
        logic [NW-1:0] e_nonce;
        int            e_begins;
    } vec_t;

    vec_t vecs[4];

    task automatic start_job(input logic [NW-1:0] ns, input logic [HW-1:0] t);
        nonce_start = ns;
        target = t;
        start_mine = 1'b1;
        @(negedge clk);
        start_mine = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 300; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        if (i == 300) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: busy stuck high, expected idle", name);
        end
    endtask

    task automatic wait_begin(input string name);
        int i;
        for (i = 0; i < 50; i++) begin
            if (hif.begin_hash) break;
            @(negedge clk);
        end
        if (i == 50) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: no begin_hash, expected one", name);
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int b0;
        respond = 1'b1;
        m_hit_nonce = v.hit_n;
        m_hit_hash = v.hit_h;
        m_miss_hash = v.miss_h;
        b0 = begins;
        start_job(v.n_start, v.tgt);
        chk({name, "_busy"}, HW'(busy), HW'(1));
        wait_idle(name);
        repeat (3) @(negedge clk);
        chk({name, "_found"}, HW'(found), HW'(v.e_found));
        chk({name, "_exh"}, HW'(exhausted), HW'(v.e_exh));
        chk({name, "_terr"}, HW'(timeout_err), HW'(0));
        chk({name, "_nonce"}, HW'(hif.nonce), HW'(v.e_nonce));
        chk({name, "_begins"}, HW'(begins - b0), HW'(v.e_begins));
        if (v.e_found)
            chk({name, "_golden"}, HW'(golden_nonce), HW'(v.e_golden));
    endtask

    initial begin
        logic [HW-1:0] teq;
        teq = {64'h1234_5678_9abc_def0, 192'h0};

        vecs[0] = '{32'd5, HW'(1) << 240, 32'd6, HW'(1) << 200,
                    HW'(1) << 250, 1'b1, 1'b0, 32'd6, 32'd6, 2};
        vecs[1] = '{32'hFFFF_FFFE, HW'(1) << 240, 32'd0, '0,
                    '1, 1'b0, 1'b1, 32'd0, 32'hFFFF_FFFF, 2};
        vecs[2] = '{32'd10, teq, 32'd12, teq - HW'(1),
                    teq, 1'b1, 1'b0, 32'd12, 32'd12, 3};
        vecs[3] = '{32'd100, HW'(1), 32'd100, '0,
                    '1, 1'b1, 1'b0, 32'd100, 32'd100, 1};

        rst = 1'b1;
        start_mine = 1'b0;
        abort = 1'b0;
        nonce_start = '0;
        target = '0;
        respond = 1'b1;
        m_hit_nonce = '0;
        m_hit_hash = '0;
        m_miss_hash = '1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_busy", HW'(busy), HW'(0));
        chk("rst_found", HW'(found), HW'(0));
        chk("rst_begin", HW'(hif.begin_hash), HW'(0));
        chk("rst_nonce", HW'(hif.nonce), HW'(0));
        chk("rst_golden", HW'(golden_nonce), HW'(0));

        for (int k = 0; k < 4; k++)
            run_vec(vecs[k], $sformatf("vec%0d", k));

        // abort in a resting state keeps sticky flags
        abort = 1'b1;
        @(negedge clk);
        @(negedge clk);
        abort = 1'b0;
        chk("idle_abort_found", HW'(found), HW'(1));
        chk("idle_abort_quit", HW'(hif.quit_hash), HW'(0));

        // timeout: hasher never answers
        begin
            int i;
            respond = 1'b0;
            start_job(32'd1, HW'(1) << 240);
            wait_begin("to");
            for (i = 1; i <= TO + 10; i++) begin
                @(negedge clk);
                if (hif.quit_hash) break;
            end
            chk("to_latency", HW'(i), HW'(TO + 1));
            chk("to_err", HW'(timeout_err), HW'(1));
            @(negedge clk);
            chk("to_idle", HW'(busy), HW'(0));
            chk("to_quit_pulse", HW'(hif.quit_hash), HW'(0));
        end

        // abort coincident with a hitting hash_done
        respond = 1'b1;
        m_hit_nonce = 32'd40;
        m_hit_hash = '0;
        m_miss_hash = '1;
        start_job(32'd40, HW'(1) << 240);
        wait_begin("ab");
        repeat (LAT) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_quit", HW'(hif.quit_hash), HW'(1));
        chk("ab_found_now", HW'(found), HW'(0));
        @(negedge clk);
        chk("ab_found", HW'(found), HW'(0));
        chk("ab_busy", HW'(busy), HW'(0));
        chk("ab_quit_pulse", HW'(hif.quit_hash), HW'(0));

        // reset while waiting, then a normal job
        start_job(32'd77, HW'(1) << 240);
        wait_begin("rw");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rw_busy", HW'(busy), HW'(0));
        chk("rw_begin", HW'(hif.begin_hash), HW'(0));
        chk("rw_quit", HW'(hif.quit_hash), HW'(0));
        chk("rw_nonce", HW'(hif.nonce), HW'(0));
        chk("rw_golden", HW'(golden_nonce), HW'(0));
        rst = 1'b0;
        @(negedge clk);
        run_vec(vecs[0], "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
